overlay_pixel_gen: RTL

OVERLAY_PIXEL_GEN -- requirements
Module: overlay_pixel_gen

---
 rtl/overlay_pixel_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/overlay_pixel_gen.sv
// Overlay pixel generator: maps a downscaled code image to RGB444 and
// drives per-button hover/press/click state machines.
module overlay_pixel_gen #(
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter int          SCALE_SHIFT = 1,
    parameter int          ADDR_W      = 17,
    parameter int          CODE_W      = 4,
    parameter int          NUM_BUTTONS = 4,
    parameter int          MEM_LATENCY = 1,
    parameter logic [11:0] FG_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter logic [11:0] TOUCH_COLOR = 12'h32E,
    parameter logic [11:0] CLICK_COLOR = 12'h3E2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [9:0]               h_cnt,
    input  logic [9:0]               v_cnt,
    input  logic                     mouse_left,
    input  logic [NUM_BUTTONS-1:0]   mouse_on_btn,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [CODE_W-1:0]        mem_code,
    output logic [11:0]              pixel_out,
    output logic                     pixel_valid,
    output logic [2*NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0]   btn_click
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOVER   = 2'd1,
        PRESSED = 2'd2,
        ILLEGAL = 2'd3
    } btn_st_e;

    localparam int IMG_W = H_RES >> SCALE_SHIFT;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
        $error("MEM_LATENCY must be 1..4");
    end
    if (NUM_BUTTONS < 1 || NUM_BUTTONS > (2**CODE_W) - 2) begin : g_bad_buttons
        $error("NUM_BUTTONS out of range for CODE_W");
    end

    logic                  visible;
    logic [ADDR_W-1:0]     addr_next;
    logic [MEM_LATENCY:0]  vis_q;
    logic [11:0]           pix_next;

    assign visible = (int'(h_cnt) < H_RES) && (int'(v_cnt) < V_RES);

    assign addr_next = ADDR_W'(32'(h_cnt >> SCALE_SHIFT)
                     + 32'(IMG_W) * 32'(v_cnt >> SCALE_SHIFT));

    // vis_q[0] lines up with mem_addr, vis_q[MEM_LATENCY] with mem_code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            vis_q    <= '0;
        end else begin
            mem_addr <= visible ? addr_next : '0;
            vis_q    <= {vis_q[MEM_LATENCY-1:0], visible};
        end
    end

    function automatic logic [11:0] state_colour(input logic [1:0] st);
        case (btn_st_e'(st))
            HOVER:   state_colour = TOUCH_COLOR;
            PRESSED: state_colour = CLICK_COLOR;
            default: state_colour = BG_COLOR;
        endcase
    endfunction

    always_comb begin
        pix_next = BG_COLOR;
        if (mem_code == CODE_W'(1)) begin
            pix_next = FG_COLOR;
        end
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            if (mem_code == CODE_W'(k + 2)) begin
                pix_next = state_colour(btn_state[2*k +: 2]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out   <= BG_COLOR;
            pixel_valid <= 1'b0;
        end else if (vis_q[MEM_LATENCY] && enable) begin
            pixel_out   <= pix_next;
            pixel_valid <= 1'b1;
        end else begin
            pixel_out   <= BG_COLOR;
            pixel_valid <= 1'b0;
        end
    end

    // Entering a button with the mouse already held never arms a click
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_state <= '0;
            btn_click <= '0;
        end else begin
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                btn_click[k] <= 1'b0;
                if (!enable) begin
                    btn_state[2*k +: 2] <= IDLE;
                end else begin
                    case (btn_st_e'(btn_state[2*k +: 2]))
                        IDLE: begin
                            if (mouse_on_btn[k] && !mouse_left)
                                btn_state[2*k +: 2] <= HOVER;
                        end
                        HOVER: begin
                            if (!mouse_on_btn[k])
                                btn_state[2*k +: 2] <= IDLE;
                            else if (mouse_left)
                                btn_state[2*k +: 2] <= PRESSED;
                        end
                        PRESSED: begin
                            if (!mouse_on_btn[k]) begin
                                btn_state[2*k +: 2] <= IDLE;
                            end else if (!mouse_left) begin
                                btn_state[2*k +: 2] <= HOVER;
                                btn_click[k]        <= 1'b1;
                            end
                        end
                        default: btn_state[2*k +: 2] <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
